beamform_read_sequencer: RTL and testbench

//  Control stage directly upstream of the BRAM beamformer. After the filter output RAM is loaded,

---
 rtl/beamform_read_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_beamform_read_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beamform_read_sequencer.sv
// Walks the filter RAM one word at a time and steps its three 32-bit slices into the beamformer.
// Optional drain watchdog enabled by defining SEQ_TIMEOUT_EN (adds TIMEOUT parameter and timeout_err_o).
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for go_i with ram_loaded_i
// S_PRIME   | address/rden presented, waiting READ_LAT clocks for RAM q
// S_SLICE   | slice_state 1..3, each held SLICE_HOLD clocks
// S_NEXT    | one clock, address advanced to the next word
// S_DRAIN   | all samples issued, waiting for beamformdone_i
// S_DONE    | one-clock done pulse back to the controller
module beamform_read_sequencer #(
  parameter int NUM_ADDRS  = 180,
  parameter int ADDR_W     = 11,
  parameter int IDX_W      = 16,
  parameter int READ_LAT   = 2,
  parameter int SLICE_HOLD = 2
`ifdef SEQ_TIMEOUT_EN
  , parameter int TIMEOUT  = 4096
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              go_i,
  input  logic              ram_loaded_i,
  input  logic              beamformdone_i,
  output logic [ADDR_W-1:0] readin_address_o,
  output logic              output_read_en_o,
  output logic [1:0]        slice_state_o,
  output logic [IDX_W-1:0]  sample_index_o,
  output logic              startbeamformer_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_err_o
);

  localparam int HOLD_MAX = (READ_LAT > SLICE_HOLD) ? READ_LAT : SLICE_HOLD;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ADDRS - 1);
  localparam logic [HOLD_W-1:0] PRIME_LD  = HOLD_W'(READ_LAT - 1);
  localparam logic [HOLD_W-1:0] SLICE_LD  = HOLD_W'(SLICE_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_SLICE, S_NEXT, S_DRAIN, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [1:0]          slice_q, slice_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]    idx_inc;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LD = TMR_W'(TIMEOUT - 1);
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                err_q, err_d;
`endif

  // Saturating increment: the index never wraps back to 0 inside a frame.
  assign idx_inc = (idx_q == {IDX_W{1'b1}}) ? idx_q : idx_q + IDX_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      slice_q <= '0;
      hold_q  <= '0;
`ifdef SEQ_TIMEOUT_EN
      tmr_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      slice_q <= slice_d;
      hold_q  <= hold_d;
`ifdef SEQ_TIMEOUT_EN
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    slice_d = slice_q;
    hold_d  = hold_q;
`ifdef SEQ_TIMEOUT_EN
    tmr_d   = tmr_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (go_i && ram_loaded_i) begin
          state_d = S_PRIME;
          addr_d  = '0;
          idx_d   = '0;
          slice_d = 2'd0;
          hold_d  = PRIME_LD;
`ifdef SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_PRIME: begin
        if (hold_q == '0) begin
          state_d = S_SLICE;
          slice_d = 2'd1;
          hold_d  = SLICE_LD;
        end else begin
          hold_d  = hold_q - HOLD_W'(1);
        end
      end
      S_SLICE: begin
        if (hold_q != '0) begin
          hold_d  = hold_q - HOLD_W'(1);
        end else if (slice_q != 2'd3) begin
          slice_d = slice_q + 2'd1;
          idx_d   = idx_inc;
          hold_d  = SLICE_LD;
        end else if (addr_q == LAST_ADDR) begin
          // Last sample index is kept on the bus through the drain.
          state_d = S_DRAIN;
          slice_d = 2'd0;
`ifdef SEQ_TIMEOUT_EN
          tmr_d   = TMR_LD;
`endif
        end else begin
          state_d = S_NEXT;
          slice_d = 2'd0;
          addr_d  = addr_q + ADDR_W'(1);
          idx_d   = idx_inc;
        end
      end
      S_NEXT: begin
        state_d = S_PRIME;
        hold_d  = PRIME_LD;
      end
      S_DRAIN: begin
        if (beamformdone_i) begin
          state_d = S_DONE;
`ifdef SEQ_TIMEOUT_EN
        end else if (tmr_q == '0) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          tmr_d   = tmr_q - TMR_W'(1);
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    output_read_en_o  = 1'b0;
    startbeamformer_o = 1'b0;
    busy_o            = 1'b0;
    done_o            = 1'b0;
    case (state_q)
      S_PRIME: begin
        output_read_en_o  = 1'b1;
        busy_o            = 1'b1;
        // Beamformer is enabled from the first slice on, so only the very first prime keeps it off.
        startbeamformer_o = (addr_q != '0);
      end
      S_SLICE, S_NEXT: begin
        output_read_en_o  = 1'b1;
        busy_o            = 1'b1;
        startbeamformer_o = 1'b1;
      end
      S_DRAIN: begin
        busy_o            = 1'b1;
        startbeamformer_o = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign readin_address_o = addr_q;
  assign slice_state_o    = slice_q;
  assign sample_index_o   = idx_q;
`ifdef SEQ_TIMEOUT_EN
  assign timeout_err_o    = err_q;
`else
  assign timeout_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_beamform_read_sequencer.sv
// Bench for beamform_read_sequencer: frame-level reference model plus a small-config instance.
module tb_beamform_read_sequencer;
  localparam int NA = 180;
  localparam int AW = 11;
  localparam int IW = 16;
  localparam int RL = 2;
  localparam int SH = 2;
`ifdef SEQ_TIMEOUT_EN
  localparam int TO = 16;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          rden;
    logic [1:0]    slice;
    logic [IW-1:0] idx;
    logic          start;
    logic          busy;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic go = 1'b0, ram_loaded = 1'b0, bfd = 1'b0;
  logic [AW-1:0] addr;
  logic rden, start, busy, done, err;
  logic [1:0] slice;
  logic [IW-1:0] idx;

  logic s_go = 1'b0, s_bfd = 1'b0;
  logic [AW-1:0] s_addr;
  logic s_rden, s_start, s_busy, s_done, s_err;
  logic [1:0] s_slice;
  logic [IW-1:0] s_idx;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  beamform_read_sequencer #(
    .NUM_ADDRS(NA), .ADDR_W(AW), .IDX_W(IW), .READ_LAT(RL), .SLICE_HOLD(SH)
`ifdef SEQ_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .go_i(go), .ram_loaded_i(ram_loaded), .beamformdone_i(bfd),
    .readin_address_o(addr), .output_read_en_o(rden), .slice_state_o(slice),
    .sample_index_o(idx), .startbeamformer_o(start), .busy_o(busy), .done_o(done),
    .timeout_err_o(err)
  );

  beamform_read_sequencer #(
    .NUM_ADDRS(4), .ADDR_W(AW), .IDX_W(IW), .READ_LAT(1), .SLICE_HOLD(1)
  ) u_small (
    .clk_i(clk), .rst_ni(rst_n), .go_i(s_go), .ram_loaded_i(ram_loaded), .beamformdone_i(s_bfd),
    .readin_address_o(s_addr), .output_read_en_o(s_rden), .slice_state_o(s_slice),
    .sample_index_o(s_idx), .startbeamformer_o(s_start), .busy_o(s_busy), .done_o(s_done),
    .timeout_err_o(s_err)
  );

  // Reference model: a frame is the list of per-cycle outputs up to the drain, then drain/done/idle.
  exp_t ex = '0;
  exp_t q[$];
  int   m_mode = 0;
  int   drain_cnt = 0;
  logic m_err = 1'b0;

  function automatic void build_frame();
    exp_t e;
    for (int w = 0; w < NA; w++) begin
      e = '0;
      e.addr  = AW'(w);
      e.rden  = 1'b1;
      e.busy  = 1'b1;
      e.idx   = IW'(3 * w);
      e.start = (w > 0);
      if (w > 0) q.push_back(e);
      for (int i = 0; i < RL; i++) q.push_back(e);
      e.start = 1'b1;
      for (int s = 1; s <= 3; s++) begin
        e.slice = 2'(s);
        e.idx   = IW'(3 * w + s - 1);
        for (int i = 0; i < SH; i++) q.push_back(e);
      end
    end
  endfunction

  function automatic exp_t drain_of(input exp_t p);
    exp_t e = p;
    e.rden = 1'b0; e.slice = 2'd0; e.start = 1'b1; e.busy = 1'b1; e.done = 1'b0;
    return e;
  endfunction

  function automatic exp_t done_of(input exp_t p);
    exp_t e = p;
    e.rden = 1'b0; e.slice = 2'd0; e.start = 1'b0; e.busy = 1'b0; e.done = 1'b1;
    return e;
  endfunction

  function automatic exp_t idle_of(input exp_t p);
    exp_t e = p;
    e.done = 1'b0;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      ex        <= '0;
      m_mode    <= 0;
      drain_cnt <= 0;
      m_err     <= 1'b0;
    end else begin
      case (m_mode)
        0: if (go && ram_loaded) begin
             build_frame();
             ex     <= q.pop_front();
             m_mode <= 1;
             m_err  <= 1'b0;
           end
        1: if (q.size() > 0) ex <= q.pop_front();
           else begin
             ex        <= drain_of(ex);
             m_mode    <= 2;
             drain_cnt <= 0;
           end
        2: if (bfd) begin
             ex     <= done_of(ex);
             m_mode <= 3;
`ifdef SEQ_TIMEOUT_EN
           end else if (drain_cnt + 1 == TO) begin
             ex     <= done_of(ex);
             m_mode <= 3;
             m_err  <= 1'b1;
`endif
           end else drain_cnt <= drain_cnt + 1;
        default: begin
          ex     <= idle_of(ex);
          m_mode <= 0;
        end
      endcase
    end
  end

  task automatic check(input string name, input longint got, input longint expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic cmp_cycle();
    logic exp_err;
`ifdef SEQ_TIMEOUT_EN
    exp_err = m_err;
`else
    exp_err = 1'b0;
`endif
    n_checks++;
    if ({addr, rden, slice, idx, start, busy, done, err} !==
        {ex.addr, ex.rden, ex.slice, ex.idx, ex.start, ex.busy, ex.done, exp_err}) begin
      n_err++;
      $display("FAIL cycle_outputs t=%0t: got addr=%0d rden=%0b slice=%0d idx=%0d start=%0b busy=%0b done=%0b err=%0b, expected addr=%0d rden=%0b slice=%0d idx=%0d start=%0b busy=%0b done=%0b err=%0b",
               $time, addr, rden, slice, idx, start, busy, done, err,
               ex.addr, ex.rden, ex.slice, ex.idx, ex.start, ex.busy, ex.done, exp_err);
    end
  endtask

  // Caller is 1ns after a rising edge. bfd_delay: >=0 clocks after drain entry, -1 already high, -2 never.
  task automatic run_frame(input int bfd_delay, input bit noise,
                           output int to_drain, output int drain_len, output int dones);
    int n, m;
    dones = 0;
    if (bfd_delay == -1) bfd = 1'b1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n = 0;
    forever begin
      if (noise) begin
        go = ($urandom_range(0, 5) == 0);
        ram_loaded = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      n++;
      if (done) dones++;
      if ((busy && !rden) || n >= 5000) break;
    end
    to_drain = n;
    go = 1'b0;
    ram_loaded = 1'b1;
    m = 0;
    forever begin
      if (bfd_delay >= 0 && m == bfd_delay) bfd = 1'b1;
      @(posedge clk); #1;
      m++;
      if (done) begin dones++; break; end
      if (m >= 5000) break;
    end
    drain_len = m;
    bfd = 1'b0;
    @(posedge clk); #1;
    if (done) dones++;
  endtask

  initial begin
    int td, dl, dn, n, m, smax_idx, smax_addr, d;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (chk_en) cmp_cycle();
      end
    join_none
    #1;
    check("reset_outputs", {addr, rden, slice, idx, start, busy, done, err}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ram_loaded = 1'b1;

    // Small configuration: 4 words, READ_LAT=1, SLICE_HOLD=1.
    s_bfd = 1'b1;
    s_go  = 1'b1;
    @(posedge clk); #1;
    s_go = 1'b0;
    n = 0; smax_idx = 0; smax_addr = 0;
    while (!(s_busy && !s_rden) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (int'(s_idx) > smax_idx) smax_idx = int'(s_idx);
      if (int'(s_addr) > smax_addr) smax_addr = int'(s_addr);
    end
    check("small_go_to_drain", n, 19);
    check("small_max_idx", smax_idx, 11);
    check("small_max_addr", smax_addr, 3);
    m = 0;
    while (!s_done && m < 50) begin @(posedge clk); #1; m++; end
    check("small_drain_len", m, 1);
    s_bfd = 1'b0;
    @(posedge clk); #1;
    check("small_done_one_cycle", s_done, 0);

    // go without ram_loaded is ignored.
    ram_loaded = 1'b0;
    go = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("go_no_ram_busy", busy, 0);
    go = 1'b0;
    ram_loaded = 1'b1;
    @(posedge clk); #1;

    // Full frame, beamformdone 5 clocks after drain entry, go/ram_loaded noise while busy.
    run_frame(5, 1'b1, td, dl, dn);
    check("frame_go_to_drain", td, 1619);
    check("frame_drain_len", dl, 6);
    check("frame_done_pulses", dn, 1);
    check("frame_last_idx", idx, 539);
    check("frame_last_addr", addr, 179);

    // beamformdone already high at drain entry.
    run_frame(-1, 1'b0, td, dl, dn);
    check("early_bfd_drain_len", dl, 1);
    check("early_bfd_done_pulses", dn, 1);

    // Reset in the middle of SLICE.
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n = 0;
    while (slice != 2'd2 && n < 100) begin @(posedge clk); #1; n++; end
    check("reached_slice2", slice, 2);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", {addr, rden, slice, idx, start, busy, done, err}, 0);
    @(posedge clk); #1;
    check("no_done_in_reset", done, 0);
    rst_n = 1'b1;
    run_frame(2, 1'b0, td, dl, dn);
    check("after_reset_go_to_drain", td, 1619);
    check("after_reset_drain_len", dl, 3);

`ifdef SEQ_TIMEOUT_EN
    run_frame(-2, 1'b0, td, dl, dn);
    check("timeout_drain_len", dl, 16);
    check("timeout_done_pulses", dn, 1);
    check("timeout_err_set", err, 1);
    run_frame(0, 1'b0, td, dl, dn);
    check("timeout_err_cleared", err, 0);
    check("post_timeout_drain_len", dl, 1);
`endif

    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(0, 10);
      run_frame(d, 1'b1, td, dl, dn);
      check("rand_go_to_drain", td, 1619);
      check("rand_drain_len", dl, d + 1);
      check("rand_done_pulses", dn, 1);
    end

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
